// File: rtl/tile_rom_arb_pkg.sv
// Shared types and default widths for the tile ROM arbiter.
// Optional build macro: TILE_ROM_ARB_FIXED_PRIO_EN (see rr_select).
package tile_rom_arb_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 64;
    localparam int BURST_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BURST = 2'd2
    } state_t;

endpackage

// File: rtl/tile_rom_arbiter_rr_select.sv
// Winner selection for the tile ROM arbiter.
// TILE_ROM_ARB_FIXED_PRIO_EN: lowest index wins, 'last' ignored.
module rr_select #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] grant,
    output logic         any
);

`ifdef TILE_ROM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = ^last;

    // Lowest set index wins; later hits overwrite higher ones.
    always_comb begin
        grant = '0;
        any   = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) grant = W'(i);
        end
    end
`else
    logic [W-1:0] idx;

    // Search from last+1 around to last; nearest hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = |req;
        for (int i = N; i >= 1; i--) begin
            idx = W'((int'(last) + i) % N);
            if (req[idx]) grant = idx;
        end
    end
`endif

endmodule

// File: rtl/tile_rom_arbiter.sv
// Shares the burst tile ROM port between N requesters.
// Build option: TILE_ROM_ARB_FIXED_PRIO_EN selects fixed priority.
module tile_rom_arbiter
    import tile_rom_arb_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int BURST_W = BURST_W_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_rd,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr,
    input  logic [N_REQ*BURST_W-1:0]   req_burst_len,
    output logic [N_REQ-1:0]           req_wait_n,
    output logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_burst_done,
    output logic [DATA_W-1:0]          req_dout,
    output logic                       rom_rd,
    output logic [ADDR_W-1:0]          rom_addr,
    output logic [BURST_W-1:0]         rom_burst_len,
    input  logic                       rom_wait_n,
    input  logic                       rom_valid,
    input  logic [DATA_W-1:0]          rom_dout,
    input  logic                       rom_burst_done,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   owner
);

    localparam int OW = $clog2(N_REQ);

    state_t        state;
    logic [OW-1:0] winner;
    logic          any_req;

    rr_select #(
        .N (N_REQ),
        .W (OW)
    ) u_sel (
        .req   (req_rd),
        .last  (owner),
        .grant (winner),
        .any   (any_req)
    );

    // Arbitration FSM: pick owner, wait for ROM accept, track burst.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            owner <= OW'(N_REQ - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner <= winner;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (!req_rd[owner])
                        state <= IDLE;
                    else if (rom_wait_n)
                        state <= BURST;
                end
                BURST: begin
                    if (rom_burst_done)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request mux toward ROM and response demux back to the owner.
    always_comb begin
        rom_rd         = 1'b0;
        rom_addr       = req_addr[owner*ADDR_W +: ADDR_W];
        rom_burst_len  = req_burst_len[owner*BURST_W +: BURST_W];
        req_wait_n     = '0;
        req_valid      = '0;
        req_burst_done = '0;
        req_dout       = rom_dout;
        busy           = (state != IDLE);
        if (state == GRANT) begin
            rom_rd            = req_rd[owner];
            req_wait_n[owner] = rom_wait_n;
        end
        if (state == BURST) begin
            req_valid[owner]      = rom_valid;
            req_burst_done[owner] = rom_burst_done;
        end
    end

endmodule

// File: tb/tb_tile_rom_arbiter.sv
// Directed self-checking bench for tile_rom_arbiter.
// Expectations follow TILE_ROM_ARB_FIXED_PRIO_EN when defined.
module tb_tile_rom_arbiter;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   req_rd;
    logic [127:0] req_addr;
    logic [31:0]  req_burst_len;
    logic [3:0]   req_wait_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_burst_done;
    logic [63:0]  req_dout;
    logic         rom_rd;
    logic [31:0]  rom_addr;
    logic [7:0]   rom_burst_len;
    logic         rom_wait_n;
    logic         rom_valid;
    logic [63:0]  rom_dout;
    logic         rom_burst_done;
    logic         busy;
    logic [1:0]   owner;

    int checks = 0;
    int errors = 0;

    tile_rom_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .req_rd         (req_rd),
        .req_addr       (req_addr),
        .req_burst_len  (req_burst_len),
        .req_wait_n     (req_wait_n),
        .req_valid      (req_valid),
        .req_burst_done (req_burst_done),
        .req_dout       (req_dout),
        .rom_rd         (rom_rd),
        .rom_addr       (rom_addr),
        .rom_burst_len  (rom_burst_len),
        .rom_wait_n     (rom_wait_n),
        .rom_valid      (rom_valid),
        .rom_dout       (rom_dout),
        .rom_burst_done (rom_burst_done),
        .busy           (busy),
        .owner          (owner)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] addr_of(int i);
        return 32'h1000_0000 + 32'(i * 256);
    endfunction

    function automatic logic [7:0] len_of(int i);
        return 8'(i + 4);
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        req_rd = 4'b0000;
        rom_wait_n = 1'b0;
        rom_valid = 1'b0;
        rom_burst_done = 1'b0;
        rom_dout = '0;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*32 +: 32] = addr_of(i);
            req_burst_len[i*8 +: 8] = len_of(i);
        end
        apply_reset();
        #1;
        checks++;
        if ({rom_rd, busy, req_wait_n, req_valid, req_burst_done} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0",
                     {rom_rd, busy, req_wait_n, req_valid, req_burst_done});
        end
        checks++;
        if (owner !== 2'd3) begin
            errors++;
            $display("FAIL reset_owner: got %0d required 3", owner);
        end
    endtask

    task automatic test_single_burst;
        req_rd = 4'b0001;
        rom_wait_n = 1'b1;
        #1;
        checks++;
        if (rom_rd !== 1'b0) begin
            errors++;
            $display("FAIL single_rd_T: got %b required 0", rom_rd);
        end
        tick();
        checks++;
        if ({rom_rd, owner, req_wait_n} !== {1'b1, 2'd0, 4'b0001}) begin
            errors++;
            $display("FAIL single_grant: got %b required 1000001",
                     {rom_rd, owner, req_wait_n});
        end
        checks++;
        if (rom_addr !== addr_of(0) || rom_burst_len !== len_of(0)) begin
            errors++;
            $display("FAIL single_addr: got %h/%0d required %h/%0d",
                     rom_addr, rom_burst_len, addr_of(0), len_of(0));
        end
        tick();
        req_rd = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            rom_valid = 1'b1;
            rom_dout = 64'hA5A5_0000_0000_0000 + 64'(b);
            rom_burst_done = (b == 3);
            #1;
            checks++;
            if (rom_rd !== 1'b0 || req_valid !== 4'b0001 ||
                req_dout !== 64'hA5A5_0000_0000_0000 + 64'(b)) begin
                errors++;
                $display("FAIL single_beat%0d: got rd=%b v=%b d=%h required 0/0001",
                         b, rom_rd, req_valid, req_dout);
            end
            checks++;
            if (req_burst_done !== ((b == 3) ? 4'b0001 : 4'b0000)) begin
                errors++;
                $display("FAIL single_done%0d: got %b", b, req_burst_done);
            end
            tick();
        end
        rom_valid = 1'b0;
        rom_burst_done = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_drop: got %b required 0", busy);
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp;
        apply_reset();
        rom_wait_n = 1'b1;
        req_rd = 4'b1111;
        for (int k = 0; k < 5; k++) begin
`ifdef TILE_ROM_ARB_FIXED_PRIO_EN
            exp = 2'd0;
`else
            exp = 2'(k % 4);
`endif
            tick();
            checks++;
            if (owner !== exp || rom_rd !== 1'b1 ||
                req_wait_n !== (4'b0001 << exp)) begin
                errors++;
                $display("FAIL rr_grant%0d: got owner=%0d rd=%b wn=%b required %0d",
                         k, owner, rom_rd, req_wait_n, exp);
            end
            checks++;
            if (rom_addr !== addr_of(int'(exp))) begin
                errors++;
                $display("FAIL rr_addr%0d: got %h required %h",
                         k, rom_addr, addr_of(int'(exp)));
            end
            tick();
            rom_valid = 1'b1;
            rom_burst_done = 1'b1;
            #1;
            checks++;
            if (req_valid !== (4'b0001 << exp) ||
                req_burst_done !== (4'b0001 << exp)) begin
                errors++;
                $display("FAIL rr_beat%0d: got v=%b d=%b required owner %0d",
                         k, req_valid, req_burst_done, exp);
            end
            tick();
            rom_valid = 1'b0;
            rom_burst_done = 1'b0;
            #1;
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL rr_idle%0d: got busy=%b required 0", k, busy);
            end
        end
        req_rd = 4'b0110;
        tick();
        checks++;
        if (owner !== 2'd1) begin
            errors++;
            $display("FAIL rr_drop0: got owner=%0d required 1", owner);
        end
        req_rd = 4'b0000;
        tick();
    endtask

    task automatic test_wait_states;
        apply_reset();
        rom_wait_n = 1'b0;
        req_rd = 4'b0100;
        tick();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (rom_rd !== 1'b1 || rom_addr !== addr_of(2) ||
                req_wait_n !== 4'b0000 || owner !== 2'd2) begin
                errors++;
                $display("FAIL wait_hold%0d: got rd=%b a=%h wn=%b o=%0d",
                         c, rom_rd, rom_addr, req_wait_n, owner);
            end
            tick();
        end
        rom_wait_n = 1'b1;
        rom_burst_done = 1'b1;
        #1;
        checks++;
        if (req_wait_n !== 4'b0100 || rom_burst_len !== len_of(2)) begin
            errors++;
            $display("FAIL wait_accept: got wn=%b len=%0d required 0100/%0d",
                     req_wait_n, rom_burst_len, len_of(2));
        end
        tick();
        rom_burst_done = 1'b0;
        req_rd = 4'b0000;
        rom_valid = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1 || rom_rd !== 1'b0 || req_valid !== 4'b0100) begin
            errors++;
            $display("FAIL wait_burst: got busy=%b rd=%b v=%b required 1/0/0100",
                     busy, rom_rd, req_valid);
        end
        rom_burst_done = 1'b1;
        tick();
        rom_valid = 1'b0;
        rom_burst_done = 1'b0;
        rom_wait_n = 1'b0;
        req_rd = 4'b1000;
        tick();
        req_rd = 4'b0000;
        #1;
        checks++;
        if (rom_rd !== 1'b0 || owner !== 2'd3) begin
            errors++;
            $display("FAIL withdraw_rd: got rd=%b o=%0d required 0/3", rom_rd, owner);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || owner !== 2'd3) begin
            errors++;
            $display("FAIL withdraw_idle: got busy=%b o=%0d required 0/3", busy, owner);
        end
    endtask

    task automatic test_spurious;
        req_rd = 4'b0000;
        rom_valid = 1'b1;
        rom_burst_done = 1'b1;
        #1;
        checks++;
        if (req_valid !== 4'b0000 || req_burst_done !== 4'b0000) begin
            errors++;
            $display("FAIL spurious_idle: got v=%b d=%b required 0", req_valid, req_burst_done);
        end
        rom_wait_n = 1'b0;
        req_rd = 4'b0010;
        tick();
        checks++;
        if (req_valid !== 4'b0000 || req_burst_done !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL spurious_grant: got v=%b d=%b busy=%b required 0/0/1",
                     req_valid, req_burst_done, busy);
        end
        req_rd = 4'b0000;
        rom_valid = 1'b0;
        rom_burst_done = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_burst;
        rom_wait_n = 1'b1;
        req_rd = 4'b0001;
        tick();
        tick();
        req_rd = 4'b0000;
        rom_valid = 1'b1;
        reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || owner !== 2'd3 || req_valid !== 4'b0000 ||
            rom_rd !== 1'b0 || req_wait_n !== 4'b0000) begin
            errors++;
            $display("FAIL midreset: got busy=%b o=%0d v=%b rd=%b wn=%b",
                     busy, owner, req_valid, rom_rd, req_wait_n);
        end
        reset = 1'b0;
        rom_valid = 1'b0;
        req_rd = 4'b0010;
        tick();
        checks++;
        if (owner !== 2'd1 || rom_rd !== 1'b1 || rom_addr !== addr_of(1)) begin
            errors++;
            $display("FAIL midreset_next: got o=%0d rd=%b a=%h required 1/1/%h",
                     owner, rom_rd, rom_addr, addr_of(1));
        end
        tick();
        req_rd = 4'b0000;
        rom_valid = 1'b1;
        rom_burst_done = 1'b1;
        #1;
        checks++;
        if (req_burst_done !== 4'b0010) begin
            errors++;
            $display("FAIL midreset_done: got %b required 0010", req_burst_done);
        end
        tick();
        rom_valid = 1'b0;
        rom_burst_done = 1'b0;
    endtask

    task automatic test_back_to_back;
        rom_wait_n = 1'b1;
        req_rd = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (owner !== 2'd3 || rom_rd !== 1'b1) begin
                errors++;
                $display("FAIL b2b_grant%0d: got o=%0d rd=%b required 3/1", k, owner, rom_rd);
            end
            tick();
            rom_burst_done = 1'b1;
            tick();
            rom_burst_done = 1'b0;
            #1;
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL b2b_gap%0d: got busy=%b required 0", k, busy);
            end
        end
        req_rd = 4'b0000;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        req_rd = '0;
        req_addr = '0;
        req_burst_len = '0;
        rom_wait_n = 1'b0;
        rom_valid = 1'b0;
        rom_dout = '0;
        rom_burst_done = 1'b0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_wait_states();
        test_spurious();
        test_reset_mid_burst();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
